tone_stepper: RTL and testbench
===============================

Name: tone_stepper

Overview:
Scheduler between the user button, the chromatic tone ROM and the sine generator's frequency input. It debounces the active-low user button and steps a tone index up or down, once per press plus auto-repeat while held. It fetches the phase increment from the synchronous tone ROM and commits it to the generator's freq input only on an LRCLK rising edge, so a note change never lands mid-sample. The index wraps cleanly inside the table, replacing the free-running index counter at top level.

Parameters:
PHASESIZE, 30, width of phase increment word.
NUM_TONES, 140, number of valid ROM entries.
ADDRSIZE, 8, ROM address width; must satisfy 2^ADDRSIZE >= NUM_TONES.
DEBOUNCE_CYCLES, 49152, clk cycles the button must be stable (1 ms at 49.152 MHz).
REPEAT_DELAY, 24576000, clk cycles held before the first auto-repeat (0.5 s).
REPEAT_PERIOD, 2457600, clk cycles between auto-repeats (50 ms).

Ports:
clk  in  1  system clock (OSC domain).
resetn  in  1  asynchronous active-low reset.
button_n  in  1  raw user button, active-low, asynchronous to clk.
dir  in  1  step direction: 1 = up, 0 = down; sampled when a step is issued.
lrclk  in  1  DAC LRCLK, asynchronous to clk.
tone_addr  out  ADDRSIZE  ROM read address.
tone_data  in  PHASESIZE  ROM read data, valid 1 clk after tone_addr is presented.
freq  out  PHASESIZE  phase increment to the sine generator.
freq_update  out  1  1-clk pulse on the cycle freq changes.
busy  out  1  high from step issue until commit.

Behaviour:
- Reset (async assert, sync deassert): all of the following are 0: index, tone_addr, freq, freq_update, busy, and the debounce/repeat counters. Debounced button = released. FSM = IDLE.
- Synchronisers: button_n and lrclk each pass through 2 flops. lrclk rising edge = sync'd high and previous sync'd low.
- Debounce: the counter resets whenever the sync'd button differs from the debounced state. When the counter reaches DEBOUNCE_CYCLES-1, the debounced state takes the sync'd value and the counter clears.
- Step request:
  - One request on each debounced press edge.
  - While held, one request when the hold counter reaches REPEAT_DELAY, then one every REPEAT_PERIOD.
  - Release clears the hold counter.
- Index arithmetic:
  - up: index = (index == NUM_TONES-1) ? 0 : index+1.
  - down: index = (index == 0) ? NUM_TONES-1 : index-1.
  - The index never leaves 0..NUM_TONES-1.
- FSM:
  - IDLE: on a step request, update index, drive tone_addr = new index, busy = 1, go to FETCH.
  - FETCH: wait 1 clk for ROM latency, go to LATCH.
  - LATCH: capture tone_data into a pending register, go to ARM.
  - ARM: wait for an lrclk rising edge. On the edge, freq = pending, freq_update = 1 for that cycle, busy = 0, go to IDLE.
- Requests while busy = 1 are dropped, not queued. This covers both auto-repeat ticks and new presses.
- A lrclk edge in the same cycle as LATCH is not used; the commit waits for the next edge.
- If lrclk is stalled (codec unconfigured), the FSM holds in ARM indefinitely and freq keeps its old value.
- Total latency: request to commit = 3 clk + time to next lrclk edge (after 2-flop sync).
- Reset mid-operation: freq returns to 0, the pending value is discarded, index returns to 0.

Decomposition:
- Shared package holds the FSM state encoding (IDLE, FETCH, LATCH, ARM) and the default timing constants for 49.152 MHz.
- One sub-module: button_debounce. It contains the 2FF sync, the debounce counter and press-edge output, and is reusable for RESET and other user inputs.
- The repeat timer, index logic and FSM stay in tone_stepper.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=40, REPEAT_PERIOD=10, NUM_TONES=140, a ROM model returning data = addr*3 with 1-clk latency, and lrclk period 16 clk.
- Reset then idle 200 clk: freq=0, busy=0, tone_addr=0, no freq_update.
- Bounce button_n low for 2 clk, high 1, low 2 → no step. Then hold low 4+ clk, release → exactly 1 step. tone_addr=1; freq=3 after the next lrclk rise; freq_update is a single pulse.
- Hold button_n low for 100 clk with dir=1 → steps at press, +40 and +50 clk later (and so on). Every commit is aligned within 3 clk after a sync'd lrclk rise.
- dir=0 from index 0, one press → index=139, freq=417. With dir=1 from index 139, one press → index=0, freq=0.
- Stall lrclk, issue a press → busy stays 1 and freq is unchanged. A second press is dropped. Restart lrclk → a single commit of the first value only.
- Assert resetn low while in ARM → freq=0, busy=0, index=0 immediately (asynchronously), and no freq_update after release.

Source files
------------

// File: rtl/tone_stepper_pkg.sv
// ---------------------------------------------------------------------------
// tone_stepper_pkg
// Shared definitions for the tone stepper:
//   - stepper_state_t : FSM encoding (IDLE, FETCH, LATCH, ARM)
//   - DEF_*           : default timing constants for a 49.152 MHz clock
//   - cnt_width()     : counter width helper, never returns 0
// ---------------------------------------------------------------------------
package tone_stepper_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_LATCH = 2'd2,
      ST_ARM   = 2'd3
   } stepper_state_t;

   localparam int DEF_DEBOUNCE_CYCLES = 49152;     // 1 ms
   localparam int DEF_REPEAT_DELAY    = 24576000;  // 0.5 s
   localparam int DEF_REPEAT_PERIOD   = 2457600;   // 50 ms

   // Bits needed to hold the values 0..n-1 (minimum 1).
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tone_stepper_button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
// Two-flop synchroniser plus stability counter for an active-low push
// button. Reusable for any slow user input.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   button_n   : raw button, active-low, asynchronous to clk
//   pressed    : debounced level, 1 = held down
//   press_edge : 1-clk pulse when the debounced state becomes pressed
// ---------------------------------------------------------------------------
module button_debounce
   import tone_stepper_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic button_n,
   output logic pressed,
   output logic press_edge
);

   localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

   logic             sync1_reg;
   logic             sync2_reg;
   logic             db_n_reg;      // debounced level, active-low
   logic [CNT_W-1:0] cnt_reg;
   logic             press_edge_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // Synchroniser and debounced state start "released" so that a
         // reset never produces a phantom press.
         sync1_reg      <= 1'b1;
         sync2_reg      <= 1'b1;
         db_n_reg       <= 1'b1;
         cnt_reg        <= '0;
         press_edge_reg <= 1'b0;
      end else begin
         sync1_reg      <= button_n;
         sync2_reg      <= sync1_reg;
         press_edge_reg <= 1'b0;
         // The counter only runs while the input disagrees with the
         // debounced state; any bounce back restarts the qualification.
         if (sync2_reg == db_n_reg) begin
            cnt_reg <= '0;
         end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            db_n_reg       <= sync2_reg;
            cnt_reg        <= '0;
            press_edge_reg <= ~sync2_reg;
         end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
         end
      end
   end

   assign pressed    = ~db_n_reg;
   assign press_edge = press_edge_reg;

endmodule

// File: rtl/tone_stepper.sv
// ---------------------------------------------------------------------------
// tone_stepper
// Steps a tone index with a debounced button (single press plus
// auto-repeat), fetches the phase increment from a synchronous tone ROM and
// commits it to the sine generator only on an LRCLK rising edge.
//   clk         : system clock
//   resetn      : asynchronous active-low reset
//   button_n    : raw user button, active-low, asynchronous
//   dir         : step direction, 1 = up, 0 = down
//   lrclk       : DAC LRCLK, asynchronous
//   tone_addr   : ROM read address (current index)
//   tone_data   : ROM read data, valid 1 clk after tone_addr
//   freq        : phase increment to the sine generator
//   freq_update : 1-clk pulse on the cycle freq changes
//   busy        : high from step issue until commit
// ---------------------------------------------------------------------------
module tone_stepper
   import tone_stepper_pkg::*;
#(
   parameter int PHASESIZE       = 30,
   parameter int NUM_TONES       = 140,
   parameter int ADDRSIZE        = 8,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 button_n,
   input  logic                 dir,
   input  logic                 lrclk,
   output logic [ADDRSIZE-1:0]  tone_addr,
   input  logic [PHASESIZE-1:0] tone_data,
   output logic [PHASESIZE-1:0] freq,
   output logic                 freq_update,
   output logic                 busy
);

   localparam int HOLD_W = cnt_width(REPEAT_DELAY + 1);

   // Reset: asserts asynchronously, releases two clocks after resetn rises.
   logic rst_meta_reg;
   logic rst_n_reg;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rst_meta_reg <= 1'b0;
         rst_n_reg    <= 1'b0;
      end else begin
         rst_meta_reg <= 1'b1;
         rst_n_reg    <= rst_meta_reg;
      end
   end

   logic pressed;
   logic press_edge;

   button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk       (clk),
      .rst_n     (rst_n_reg),
      .button_n  (button_n),
      .pressed   (pressed),
      .press_edge(press_edge)
   );

   // LRCLK synchroniser and rising-edge detect.
   logic lr_sync1_reg;
   logic lr_sync2_reg;
   logic lr_prev_reg;
   logic lrclk_rise;

   always_ff @(posedge clk or negedge rst_n_reg) begin
      if (!rst_n_reg) begin
         lr_sync1_reg <= 1'b0;
         lr_sync2_reg <= 1'b0;
         lr_prev_reg  <= 1'b0;
      end else begin
         lr_sync1_reg <= lrclk;
         lr_sync2_reg <= lr_sync1_reg;
         lr_prev_reg  <= lr_sync2_reg;
      end
   end

   assign lrclk_rise = lr_sync2_reg & ~lr_prev_reg;

   // Hold timer: the press edge is cycle 0; the first repeat fires at
   // REPEAT_DELAY, then the counter is rewound so it hits REPEAT_DELAY
   // again every REPEAT_PERIOD cycles.
   logic [HOLD_W-1:0] hold_cnt_reg;
   logic              repeat_req;
   logic              step_req;

   assign repeat_req = pressed && (hold_cnt_reg == HOLD_W'(REPEAT_DELAY));
   assign step_req   = press_edge | repeat_req;

   always_ff @(posedge clk or negedge rst_n_reg) begin
      if (!rst_n_reg) begin
         hold_cnt_reg <= '0;
      end else if (!pressed) begin
         hold_cnt_reg <= '0;
      end else if (repeat_req) begin
         hold_cnt_reg <= HOLD_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);
      end else begin
         hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
      end
   end

   // Wrapping index arithmetic; the index stays inside 0..NUM_TONES-1.
   logic [ADDRSIZE-1:0] index_reg;
   logic [ADDRSIZE-1:0] index_next;

   always_comb begin
      index_next = index_reg;
      if (dir) begin
         index_next = (index_reg == ADDRSIZE'(NUM_TONES - 1)) ? '0
                                                              : index_reg + ADDRSIZE'(1);
      end else begin
         index_next = (index_reg == '0) ? ADDRSIZE'(NUM_TONES - 1)
                                        : index_reg - ADDRSIZE'(1);
      end
   end

   // Step FSM. Requests outside IDLE are simply ignored (dropped).
   stepper_state_t       state_reg;
   logic [PHASESIZE-1:0] pending_reg;
   logic [PHASESIZE-1:0] freq_reg;
   logic                 freq_update_reg;
   logic                 busy_reg;

   always_ff @(posedge clk or negedge rst_n_reg) begin
      if (!rst_n_reg) begin
         state_reg       <= ST_IDLE;
         index_reg       <= '0;
         pending_reg     <= '0;
         freq_reg        <= '0;
         freq_update_reg <= 1'b0;
         busy_reg        <= 1'b0;
      end else begin
         freq_update_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (step_req) begin
                  index_reg <= index_next;
                  busy_reg  <= 1'b1;
                  state_reg <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               state_reg <= ST_LATCH;
            end
            ST_LATCH: begin
               // An LRCLK edge seen in this cycle is deliberately not used.
               pending_reg <= tone_data;
               state_reg   <= ST_ARM;
            end
            ST_ARM: begin
               if (lrclk_rise) begin
                  freq_reg        <= pending_reg;
                  freq_update_reg <= 1'b1;
                  busy_reg        <= 1'b0;
                  state_reg       <= ST_IDLE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign tone_addr   = index_reg;
   assign freq        = freq_reg;
   assign freq_update = freq_update_reg;
   assign busy        = busy_reg;

endmodule

// File: tb/tb_tone_stepper.sv
// ---------------------------------------------------------------------------
// tb_tone_stepper
// Directed bench for tone_stepper with short timing constants, a ROM model
// returning addr*3 one clock after the address, and a 16-clk LRCLK that can
// be stalled.
// ---------------------------------------------------------------------------
module tb_tone_stepper;

   localparam int PHASESIZE = 30;
   localparam int ADDRSIZE  = 8;

   logic                 clk = 1'b0;
   logic                 resetn;
   logic                 button_n;
   logic                 dir;
   logic                 lrclk;
   logic [ADDRSIZE-1:0]  tone_addr;
   logic [PHASESIZE-1:0] tone_data = '0;
   logic [PHASESIZE-1:0] freq;
   logic                 freq_update;
   logic                 busy;

   tone_stepper #(
      .PHASESIZE      (PHASESIZE),
      .NUM_TONES      (140),
      .ADDRSIZE       (ADDRSIZE),
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY   (40),
      .REPEAT_PERIOD  (10)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .button_n   (button_n),
      .dir        (dir),
      .lrclk      (lrclk),
      .tone_addr  (tone_addr),
      .tone_data  (tone_data),
      .freq       (freq),
      .freq_update(freq_update),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Synchronous tone ROM model: data = addr * 3, one clock latency.
   always @(posedge clk) tone_data <= PHASESIZE'(tone_addr) * PHASESIZE'(3);

   int n_checks    = 0;
   int n_errors    = 0;
   int upd_cnt     = 0;
   int long_pulses = 0;
   int since_rise  = 0;
   int lr_ph       = 0;
   bit lr_stall    = 1'b0;
   bit prev_upd    = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end else begin
         $display("ok   %s: got %0d", tag, obs);
      end
   endtask

   // LRCLK: toggles every 8 clk unless stalled; since_rise counts clk edges
   // since the raw rising edge.
   initial begin
      lrclk = 1'b0;
      forever begin
         @(posedge clk);
         since_rise++;
         #1;
         if (!lr_stall) begin
            lr_ph++;
            if (lr_ph == 8) begin
               lr_ph = 0;
               lrclk = ~lrclk;
               if (lrclk) since_rise = 0;
            end
         end
      end
   end

   // Commit monitor: 2-flop sync + edge detect + registered commit puts
   // every commit exactly 3 clk after the raw LRCLK rise.
   always @(negedge clk) begin
      if (resetn && freq_update) begin
         upd_cnt++;
         check("commit_align", since_rise, 3);
         check("commit_freq", freq, 32'(tone_addr) * 3);
         if (prev_upd) long_pulses++;
      end
      prev_upd = freq_update;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input int n_low);
      button_n = 1'b0;
      tick(n_low);
      button_n = 1'b1;
      tick(10);
   endtask

   task automatic wait_upd(input int target, input int budget, input string tag);
      int i = 0;
      while (upd_cnt < target && i < budget) begin
         @(negedge clk);
         i++;
      end
      check(tag, (upd_cnt >= target), 1);
   endtask

   task automatic wait_idle(input int budget);
      int i = 0;
      while (busy && i < budget) begin
         @(negedge clk);
         i++;
      end
      check("idle_timeout", busy, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int n;
      resetn   = 1'b0;
      button_n = 1'b1;
      dir      = 1'b1;
      tick(5);
      resetn = 1'b1;
      tick(200);
      check("rst_freq", freq, 0);
      check("rst_busy", busy, 0);
      check("rst_addr", tone_addr, 0);
      check("rst_upd", upd_cnt, 0);

      // Bounce shorter than the debounce window: no step.
      button_n = 1'b0; tick(2);
      button_n = 1'b1; tick(1);
      button_n = 1'b0; tick(2);
      button_n = 1'b1; tick(40);
      check("bounce_upd", upd_cnt, 0);
      check("bounce_busy", busy, 0);
      check("bounce_addr", tone_addr, 0);

      // Clean single press: one step to index 1.
      press(8);
      wait_upd(1, 100, "single_timeout");
      tick(40);
      check("single_addr", tone_addr, 1);
      check("single_freq", freq, 3);
      check("single_cnt", upd_cnt, 1);
      check("single_busy", busy, 0);

      // Long hold: press step + auto-repeats; requests while busy drop.
      base = upd_cnt;
      button_n = 1'b0;
      tick(100);
      button_n = 1'b1;
      tick(10);
      wait_idle(100);
      tick(5);
      n = upd_cnt - base;
      check("hold_min3", (n >= 3), 1);
      check("hold_max7", (n <= 7), 1);
      check("hold_addr", tone_addr, 32'(1 + n));
      check("hold_freq", freq, 32'(3 * (1 + n)));
      check("pulse_width", long_pulses, 0);
      tick(60);
      check("hold_stable", upd_cnt, base + n);

      // Wrap-around both ways from index 0.
      resetn = 1'b0; tick(3);
      resetn = 1'b1; tick(5);
      check("wrap_rst_addr", tone_addr, 0);
      check("wrap_rst_freq", freq, 0);
      base = upd_cnt;
      dir = 1'b0;
      press(8);
      wait_upd(base + 1, 100, "down_timeout");
      tick(5);
      check("down_addr", tone_addr, 139);
      check("down_freq", freq, 417);
      dir = 1'b1;
      press(8);
      wait_upd(base + 2, 100, "up_timeout");
      tick(5);
      check("up_addr", tone_addr, 0);
      check("up_freq", freq, 0);

      // Stalled LRCLK: hold in ARM, drop a second press, one commit later.
      press(8);
      wait_upd(base + 3, 100, "pre_stall_timeout");
      tick(5);
      check("pre_stall_freq", freq, 3);
      lr_stall = 1'b1;
      base = upd_cnt;
      press(8);
      tick(50);
      check("stall_busy", busy, 1);
      check("stall_freq", freq, 3);
      check("stall_addr", tone_addr, 2);
      check("stall_upd", upd_cnt, base);
      press(8);
      tick(20);
      check("drop_addr", tone_addr, 2);
      check("drop_busy", busy, 1);
      lr_stall = 1'b0;
      wait_upd(base + 1, 100, "restart_timeout");
      tick(60);
      check("restart_cnt", upd_cnt, base + 1);
      check("restart_freq", freq, 6);
      check("restart_addr", tone_addr, 2);
      check("restart_busy", busy, 0);

      // Reset while waiting in ARM: clears immediately, no late commit.
      lr_stall = 1'b1;
      base = upd_cnt;
      press(8);
      tick(20);
      check("arm_busy", busy, 1);
      resetn = 1'b0;
      #2;
      check("arm_rst_freq", freq, 0);
      check("arm_rst_busy", busy, 0);
      check("arm_rst_addr", tone_addr, 0);
      tick(4);
      resetn = 1'b1;
      lr_stall = 1'b0;
      tick(60);
      check("arm_no_upd", upd_cnt, base);
      check("arm_freq", freq, 0);
      check("arm_busy_after", busy, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
